// File: rtl/rcv_frame_shifter.sv
// ============================================================================
// rcv_frame_shifter : UART receive shift register, parity/stop check, output buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module rcv_frame_shifter #(
  parameter int DATA_BITS  = 8,
  parameter int SHIFT_MSB  = 0,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start_detected,
  input  logic                 shift_strobe,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 2);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_M1  = CNT_W'(DATA_BITS + PARITY_EN - 1);
  localparam logic PAR_ON  = (PARITY_EN != 0);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [DATA_BITS-1:0] sr;
  logic [DATA_BITS-1:0] sr_shifted;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 par;
  logic                 stop_bit;

  generate
    if (SHIFT_MSB != 0) begin : g_msb_first
      assign sr_shifted = {sr[DATA_BITS-2:0], serial_in};
    end else begin : g_lsb_first
      assign sr_shifted = {serial_in, sr[DATA_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_detected) state_next = SHIFT;
      SHIFT:   if (shift_strobe && (bit_cnt == LAST_M1)) state_next = STOP;
      STOP:    if (shift_strobe) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr            <= '0;
      bit_cnt       <= '0;
      par           <= 1'b0;
      stop_bit      <= 1'b0;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);

      // A read outside LOAD releases the buffer; LOAD resolves the read itself.
      if ((state != LOAD) && data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_detected) begin
            bit_cnt       <= '0;
            framing_error <= 1'b0;
          end
        end
        SHIFT: begin
          if (shift_strobe) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt < DATA_CNT) begin
              sr <= sr_shifted;
            end else if (PAR_ON) begin
              par <= serial_in;
            end
          end
        end
        STOP: begin
          if (shift_strobe) begin
            stop_bit <= serial_in;
          end
        end
        LOAD: begin
          if (stop_bit) begin
            rx_data       <= sr;
            data_ready    <= 1'b1;
            parity_error  <= PAR_ON & ((^sr) ^ par ^ ODD_BIT);
            overrun_error <= data_ready & ~data_read;
          end else begin
            framing_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rcv_frame_shifter.sv
// ============================================================================
// tb_rcv_frame_shifter : directed table, corner sequences and randomized frames
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rcv_frame_shifter;

  logic       clk;
  logic       n_rst;
  logic [5:0] st, sb, si, rd;
  logic [5:0] rdy, perr, ferr, ovr, bsy;
  logic [7:0]  rx0, rx1, rx2, rx3;
  logic [4:0]  rx4;
  logic [15:0] rx5;

  int n_chk  = 0;
  int n_pass = 0;

  // Instance configuration: width, msb-first, parity enable, odd parity
  int p_w    [6] = '{8, 8, 8, 8, 5, 16};
  bit p_msb  [6] = '{0, 1, 0, 0, 1, 0};
  bit p_pen  [6] = '{0, 0, 1, 1, 1, 0};
  bit p_podd [6] = '{0, 0, 0, 1, 1, 0};

  logic [15:0] m_data [6];
  bit m_rdy [6], m_perr [6], m_ferr [6], m_ovr [6];

  rcv_frame_shifter u_dut0 (
    .clk(clk), .n_rst(n_rst), .start_detected(st[0]), .shift_strobe(sb[0]),
    .serial_in(si[0]), .data_read(rd[0]), .rx_data(rx0), .data_ready(rdy[0]),
    .parity_error(perr[0]), .framing_error(ferr[0]), .overrun_error(ovr[0]), .busy(bsy[0]));

  rcv_frame_shifter #(.SHIFT_MSB(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .start_detected(st[1]), .shift_strobe(sb[1]),
    .serial_in(si[1]), .data_read(rd[1]), .rx_data(rx1), .data_ready(rdy[1]),
    .parity_error(perr[1]), .framing_error(ferr[1]), .overrun_error(ovr[1]), .busy(bsy[1]));

  rcv_frame_shifter #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .start_detected(st[2]), .shift_strobe(sb[2]),
    .serial_in(si[2]), .data_read(rd[2]), .rx_data(rx2), .data_ready(rdy[2]),
    .parity_error(perr[2]), .framing_error(ferr[2]), .overrun_error(ovr[2]), .busy(bsy[2]));

  rcv_frame_shifter #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut3 (
    .clk(clk), .n_rst(n_rst), .start_detected(st[3]), .shift_strobe(sb[3]),
    .serial_in(si[3]), .data_read(rd[3]), .rx_data(rx3), .data_ready(rdy[3]),
    .parity_error(perr[3]), .framing_error(ferr[3]), .overrun_error(ovr[3]), .busy(bsy[3]));

  rcv_frame_shifter #(.DATA_BITS(5), .SHIFT_MSB(1), .PARITY_EN(1), .PARITY_ODD(1)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .start_detected(st[4]), .shift_strobe(sb[4]),
    .serial_in(si[4]), .data_read(rd[4]), .rx_data(rx4), .data_ready(rdy[4]),
    .parity_error(perr[4]), .framing_error(ferr[4]), .overrun_error(ovr[4]), .busy(bsy[4]));

  rcv_frame_shifter #(.DATA_BITS(16)) u_dut5 (
    .clk(clk), .n_rst(n_rst), .start_detected(st[5]), .shift_strobe(sb[5]),
    .serial_in(si[5]), .data_read(rd[5]), .rx_data(rx5), .data_ready(rdy[5]),
    .parity_error(perr[5]), .framing_error(ferr[5]), .overrun_error(ovr[5]), .busy(bsy[5]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] get_rx(input int idx);
    case (idx)
      0: return {8'h00, rx0};
      1: return {8'h00, rx1};
      2: return {8'h00, rx2};
      3: return {8'h00, rx3};
      4: return {11'h000, rx4};
      default: return rx5;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_out(input int idx, input logic [15:0] e_data, input bit e_rdy,
                           input bit e_perr, input bit e_ferr, input bit e_ovr, input string tag);
    check($sformatf("%s[%0d] rx_data", tag, idx), 32'(get_rx(idx)), 32'(e_data));
    check($sformatf("%s[%0d] data_ready", tag, idx), 32'(rdy[idx]), 32'(e_rdy));
    check($sformatf("%s[%0d] parity_error", tag, idx), 32'(perr[idx]), 32'(e_perr));
    check($sformatf("%s[%0d] framing_error", tag, idx), 32'(ferr[idx]), 32'(e_ferr));
    check($sformatf("%s[%0d] overrun_error", tag, idx), 32'(ovr[idx]), 32'(e_ovr));
    check($sformatf("%s[%0d] busy", tag, idx), 32'(bsy[idx]), 32'd0);
  endtask

  task automatic check_model(input int idx, input string tag);
    check_out(idx, m_data[idx], m_rdy[idx], m_perr[idx], m_ferr[idx], m_ovr[idx], tag);
  endtask

  // One clock edge with the given inputs; returns at the following falling edge.
  task automatic cycle(input int idx, input bit s, input bit b, input bit d, input bit r);
    st[idx] = s; sb[idx] = b; si[idx] = d; rd[idx] = r;
    @(posedge clk);
    @(negedge clk);
    st[idx] = 1'b0; sb[idx] = 1'b0; si[idx] = 1'b0; rd[idx] = 1'b0;
  endtask

  task automatic gaps(input int idx, input bit noise);
    int n;
    n = noise ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < n; g++) cycle(idx, bit'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
  endtask

  // Start pulse through the stop-bit strobe; the LOAD cycle is left to the caller.
  task automatic frame_body(input int idx, input logic [16:0] line, input int nbits,
                            input bit stop, input bit noise);
    if (noise) begin
      for (int k = 0; k < 2; k++) cycle(idx, 1'b0, 1'b1, bit'($urandom_range(0, 1)), 1'b0);
    end
    cycle(idx, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      gaps(idx, noise);
      cycle(idx, 1'b0, 1'b1, line[i], 1'b0);
    end
    gaps(idx, noise);
    cycle(idx, 1'b0, 1'b1, stop, 1'b0);
  endtask

  task automatic run_frame(input int idx, input logic [16:0] line, input int nbits,
                           input bit stop, input bit rd_load, input bit noise);
    frame_body(idx, line, nbits, stop, noise);
    cycle(idx, 1'b0, 1'b0, 1'b0, rd_load);
  endtask

  // Reference model: payload is the received bits placed by line order.
  task automatic model_frame(input int idx, input logic [16:0] line, input bit stop, input bit rd_load);
    logic [15:0] v;
    int w, ones;
    w = p_w[idx]; v = '0; ones = 0;
    for (int i = 0; i < w; i++) begin
      if (p_msb[idx]) v[w-1-i] = line[i];
      else v[i] = line[i];
      ones += int'(line[i]);
    end
    m_ferr[idx] = !stop;
    if (stop) begin
      m_ovr[idx]  = m_rdy[idx] && !rd_load;
      m_rdy[idx]  = 1'b1;
      m_data[idx] = v;
      m_perr[idx] = p_pen[idx] && (((ones + int'(line[w]) + int'(p_podd[idx])) % 2) == 1);
    end
  endtask

  task automatic model_read(input int idx);
    m_rdy[idx] = 1'b0;
    m_ovr[idx] = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_data[i] = '0; m_rdy[i] = 0; m_perr[i] = 0; m_ferr[i] = 0; m_ovr[i] = 0;
    end
  endtask

  typedef struct {
    int          idx;
    logic [16:0] line;
    int          nbits;
    bit          stop;
    bit          rd_pre;
    bit          rd_load;
    logic [15:0] e_data;
    bit          e_rdy, e_perr, e_ferr, e_ovr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{0, 17'h000A5, 8, 1, 0, 0, 16'h00A5, 1, 0, 0, 0};
    tbl[1]  = '{0, 17'h00003, 8, 1, 1, 0, 16'h0003, 1, 0, 0, 0};
    tbl[2]  = '{0, 17'h00055, 8, 1, 1, 0, 16'h0055, 1, 0, 0, 0};
    tbl[3]  = '{0, 17'h0003C, 8, 0, 0, 0, 16'h0055, 1, 0, 1, 0};
    tbl[4]  = '{0, 17'h00011, 8, 1, 1, 0, 16'h0011, 1, 0, 0, 0};
    tbl[5]  = '{0, 17'h00022, 8, 1, 0, 0, 16'h0022, 1, 0, 0, 1};
    tbl[6]  = '{0, 17'h00044, 8, 1, 0, 1, 16'h0044, 1, 0, 0, 0};
    tbl[7]  = '{1, 17'h000A5, 8, 1, 0, 0, 16'h00A5, 1, 0, 0, 0};
    tbl[8]  = '{1, 17'h00003, 8, 1, 1, 0, 16'h00C0, 1, 0, 0, 0};
    tbl[9]  = '{2, 17'h00107, 9, 1, 0, 0, 16'h0007, 1, 0, 0, 0};
    tbl[10] = '{2, 17'h00007, 9, 1, 1, 0, 16'h0007, 1, 1, 0, 0};
    tbl[11] = '{3, 17'h00107, 9, 1, 0, 0, 16'h0007, 1, 1, 0, 0};
    tbl[12] = '{3, 17'h00007, 9, 1, 1, 0, 16'h0007, 1, 0, 0, 0};

    st = '0; sb = '0; si = '0; rd = '0;
    n_rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) check_out(i, 16'h0, 0, 0, 0, 0, "reset");
    n_rst = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 13; t++) begin
      if (tbl[t].rd_pre) cycle(tbl[t].idx, 1'b0, 1'b0, 1'b0, 1'b1);
      run_frame(tbl[t].idx, tbl[t].line, tbl[t].nbits, tbl[t].stop, tbl[t].rd_load, 1'b0);
      check_out(tbl[t].idx, tbl[t].e_data, tbl[t].e_rdy, tbl[t].e_perr, tbl[t].e_ferr,
                tbl[t].e_ovr, $sformatf("vec%0d", t));
    end

    // Overrun then read clears ready and overrun but keeps data
    run_frame(0, 17'h00066, 8, 1'b1, 1'b0, 1'b0);
    check_out(0, 16'h0066, 1, 0, 0, 1, "ovr_set");
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_out(0, 16'h0066, 0, 0, 0, 0, "read_clr");

    // Outputs appear only at the second edge after the stop strobe
    frame_body(0, 17'h0005A, 8, 1'b1, 1'b0);
    check("lat rdy_early", 32'(rdy[0]), 32'd0);
    check("lat busy_load", 32'(bsy[0]), 32'd1);
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out(0, 16'h005A, 1, 0, 0, 0, "latency");

    // Framing error holds until the next accepted start
    run_frame(0, 17'h0003C, 8, 1'b0, 1'b0, 1'b0);
    check_out(0, 16'h005A, 1, 0, 1, 0, "ferr_set");
    cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ferr cleared", 32'(ferr[0]), 32'd0);
    check("ferr busy", 32'(bsy[0]), 32'd1);
    for (int i = 0; i < 8; i++) cycle(0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out(0, 16'h00FF, 1, 0, 0, 1, "ferr_frame");

    // Asynchronous reset in the middle of a frame
    cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) check_out(i, 16'h0, 0, 0, 0, 0, "async_rst");
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    @(negedge clk);

    // Spurious strobes in IDLE and start pulses mid-frame are ignored
    run_frame(0, 17'h000F0, 8, 1'b1, 1'b0, 1'b1);
    model_frame(0, 17'h000F0, 1'b1, 1'b0);
    check("noisy rx_data", 32'(get_rx(0)), 32'h0000_00F0);
    check_model(0, "noisy");

    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (k == 0) ? 0 : ((k == 1) ? 4 : 5);
      for (int f = 0; f < 40; f++) begin
        logic [16:0] line;
        bit stop, rdl;
        line = 17'($urandom);
        stop = ($urandom_range(0, 4) != 0);
        rdl  = ($urandom_range(0, 3) == 0);
        run_frame(idx, line, p_w[idx] + int'(p_pen[idx]), stop, rdl, 1'b1);
        model_frame(idx, line, stop, rdl);
        check_model(idx, "rand");
        if ($urandom_range(0, 2) == 0) begin
          cycle(idx, 1'b0, 1'b0, 1'b0, 1'b1);
          model_read(idx);
          check_model(idx, "rand_read");
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rcv_frame_shifter.md
Name: rcv_frame_shifter

Overview:
- Parametrised successor to the fixed 8-bit receive shift register. Adds configurable data width, shift direction, optional parity, bit counting, stop-bit check and an output holding buffer with a ready/read handshake.
- Sits in the UART receive path between the start-bit detector / timer (which supply `start_detected` and `shift_strobe`) and the consumer, which reads `rx_data`.

Parameters:
- DATA_BITS, 8: payload width, legal range 5..16.
- SHIFT_MSB, 0: 0 = first received bit ends in `rx_data[0]` (LSB-first line); 1 = first received bit ends in `rx_data[DATA_BITS-1]`.
- PARITY_EN, 0: 1 = one parity bit follows the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
- clk  in  1  system clock, rising-edge.
- n_rst  in  1  asynchronous active-low reset.
- start_detected  in  1  one-cycle pulse: start bit validated, frame begins.
- shift_strobe  in  1  one-cycle pulse at each bit-centre sample point.
- serial_in  in  1  synchronised serial line.
- data_read  in  1  consumer has taken `rx_data`.
- rx_data  out  DATA_BITS  last good payload.
- data_ready  out  1  `rx_data` holds unread data.
- parity_error  out  1  parity status of the frame in `rx_data`.
- framing_error  out  1  last frame had stop bit = 0.
- overrun_error  out  1  a good frame overwrote unread data.
- busy  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset (async, n_rst=0): state=IDLE; shift reg, bit counter, parity flop, `rx_data` = 0; all flag outputs = 0. Applies mid-frame; the partial frame is discarded.
- States: IDLE, SHIFT, STOP, LOAD. All outputs are registered.
- IDLE:
  - `start_detected` -> SHIFT, bit_cnt <= 0, framing_error <= 0.
  - `shift_strobe` is ignored.
- SHIFT: on each `shift_strobe`, bit_cnt <= bit_cnt+1, and:
  - While bit_cnt < DATA_BITS:
    - SHIFT_MSB=0: sr <= {serial_in, sr[DATA_BITS-1:1]}.
    - SHIFT_MSB=1: sr <= {sr[DATA_BITS-2:0], serial_in}.
  - When bit_cnt == DATA_BITS and PARITY_EN=1: par <= serial_in; the shift register is not shifted.
  - On the strobe that makes bit_cnt == DATA_BITS+PARITY_EN -> STOP.
  - Cycles without a strobe hold all state; strobe spacing is unconstrained.
- STOP: on `shift_strobe`, stop <= serial_in -> LOAD.
- LOAD: exactly one cycle, then -> IDLE. At the exiting edge:
  - If stop=1:
    - rx_data <= sr; data_ready <= 1.
    - parity_error <= PARITY_EN & (^sr ^ par ^ PARITY_ODD).
    - overrun_error <= data_ready & ~data_read.
  - If stop=0:
    - framing_error <= 1.
    - rx_data, data_ready, parity_error and overrun_error are unchanged; payload dropped.
- Latency: outputs update 2 clk edges after the edge that samples the stop-bit strobe (STOP->LOAD edge, then LOAD->IDLE edge).
- Handshake:
  - `data_read` high in any non-LOAD cycle: data_ready <= 0 and overrun_error <= 0 at the next edge.
  - `data_read` in the LOAD cycle with a good stop bit: new data wins (data_ready=1, overrun_error=0).
  - `data_read` with data_ready=0 has no effect.
- `start_detected` outside IDLE is ignored. The receiver does not resynchronise mid-frame.
- framing_error is held until the next accepted `start_detected`.
- parity_error is held until the next good frame. It is never cleared by `data_read`.
- busy = 1 in SHIFT, STOP and LOAD.

Test Plan:
- Default params: reset, start, 8 strobes with serial_in = 1,0,1,0,0,1,0,1, then stop=1 -> rx_data=0xA5, data_ready=1 two edges after the stop strobe, all errors 0, busy=0.
- SHIFT_MSB=1, DATA_BITS=8: same bit sequence -> rx_data=0xA5 reversed = 0xA5 (palindrome check), so also send 1,1,0,0,0,0,0,0 -> rx_data=0xC0. With SHIFT_MSB=0 the same sequence -> 0x03.
- PARITY_EN=1, PARITY_ODD=0: data 0x07 (LSB-first) with parity bit 1 -> parity_error=0; with parity bit 0 -> parity_error=1 and data_ready=1. Repeat with PARITY_ODD=1 -> results inverted.
- Good frame 0x55 with no `data_read`, then frame 0x3C with stop=0 -> framing_error=1, rx_data stays 0x55, data_ready=1, overrun_error=0. Next start -> framing_error=0.
- Two good frames 0x11 then 0x22 without `data_read` -> rx_data=0x22, overrun_error=1. Pulse `data_read` -> data_ready=0, overrun_error=0. Repeat with `data_read` coincident with LOAD -> data_ready=1, overrun_error=0.
- Assert n_rst low after 4 data strobes -> all outputs 0, busy=0 immediately (async). Release, then a full frame 0xF0 -> rx_data=0xF0. Extra start pulses and strobes mid-frame or in IDLE do not corrupt the result.
